// File: rtl/pc_stack_fetch_if.sv
// pc_stack_fetch_if: decoder sequencing controls toward the pc/stack stage,
// fetch address and return-stack status back.
interface pc_stack_fetch_if #(
    parameter int PC_WIDTH    = 10,
    parameter int STACK_DEPTH = 8
);
    localparam int SP_WIDTH = $clog2(STACK_DEPTH) + 1;

    logic                s_inc;
    logic                s_pila;
    logic                push;
    logic                pop;
    logic [PC_WIDTH-1:0] jump_addr;
    logic [PC_WIDTH-1:0] pc;
    logic [SP_WIDTH-1:0] sp;
    logic                stack_full;
    logic                stack_empty;
    logic                stack_overflow;
    logic                stack_underflow;

    modport master (
        output s_inc, s_pila, push, pop, jump_addr,
        input  pc, sp, stack_full, stack_empty, stack_overflow, stack_underflow
    );

    modport slave (
        input  s_inc, s_pila, push, pop, jump_addr,
        output pc, sp, stack_full, stack_empty, stack_overflow, stack_underflow
    );
endinterface

// File: rtl/pc_stack_fetch.sv
// pc_stack_fetch: program counter plus return-address LIFO with sticky error flags.
// Define PC_STACK_STALL_EN to add a stall input that freezes all state.
module pc_stack_fetch #(
    parameter int PC_WIDTH    = 10,
    parameter int STACK_DEPTH = 8
) (
    input  logic clk,
    input  logic reset,
`ifdef PC_STACK_STALL_EN
    input  logic stall,
`endif
    pc_stack_fetch_if.slave bus
);
    localparam int SPW = $clog2(STACK_DEPTH) + 1;

    logic [PC_WIDTH-1:0] stack [STACK_DEPTH];
    logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc;
    logic [SPW-1:0]      sp_q, sp_d;
    logic [SPW-2:0]      wr_idx, top_idx;
    logic                ovf_q, unf_q, full, empty, adv;
    logic                do_pop, do_push, ovf_evt, unf_evt, ret;

`ifdef PC_STACK_STALL_EN
    assign adv = !stall;
`else
    assign adv = 1'b1;
`endif

    assign full    = sp_q == SPW'(STACK_DEPTH);
    assign empty   = sp_q == '0;
    assign pc_inc  = pc_q + PC_WIDTH'(1);
    // Low sp bits address the slot above the top; one less is the top itself.
    assign wr_idx  = sp_q[SPW-2:0];
    assign top_idx = wr_idx - (SPW-1)'(1);
    // A pop always wins over a simultaneous push, which is then silently dropped.
    assign do_pop  = bus.pop && !empty;
    assign do_push = bus.push && !bus.pop && !full;
    assign ovf_evt = bus.push && !bus.pop && full;
    assign unf_evt = bus.pop && empty;
    assign ret     = bus.s_pila && bus.pop;

    always_comb begin
        pc_d = do_pop && ret ? stack[top_idx] :
               ret           ? pc_inc :
               !bus.s_inc    ? bus.jump_addr : pc_inc;
        sp_d = do_pop  ? sp_q - SPW'(1) :
               do_push ? sp_q + SPW'(1) : sp_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= '0;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (adv) begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_q | ovf_evt;
            unf_q <= unf_q | unf_evt;
        end
    end

    // Entry contents need no reset; sp alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (adv && do_push)
            stack[wr_idx] <= pc_inc;
    end

    assign bus.pc              = pc_q;
    assign bus.sp              = sp_q;
    assign bus.stack_full      = full;
    assign bus.stack_empty     = empty;
    assign bus.stack_overflow  = ovf_q;
    assign bus.stack_underflow = unf_q;
endmodule

// File: tb/tb_pc_stack_fetch.sv
// tb_pc_stack_fetch: directed and random sequencing against a queue-based
// return-stack model; a monitor checks each DUT update from a scoreboard.
module tb_pc_stack_fetch;
    localparam int PW  = 10;
    localparam int D   = 8;
    localparam int SPW = $clog2(D) + 1;

    typedef struct {
        logic [PW-1:0]  pc;
        logic [SPW-1:0] sp;
        logic           full, empty, ovf, unf;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic st = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t q[$];
    event sample_ev;

    logic [PW-1:0] m_pc = '0;
    logic [PW-1:0] m_stk[$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    pc_stack_fetch_if #(.PC_WIDTH(PW), .STACK_DEPTH(D)) bus ();

    pc_stack_fetch #(.PC_WIDTH(PW), .STACK_DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef PC_STACK_STALL_EN
        .stall (st),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t snapshot();
        exp_t e;
        e.pc    = m_pc;
        e.sp    = SPW'(m_stk.size());
        e.full  = m_stk.size() == D;
        e.empty = m_stk.size() == 0;
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        return e;
    endfunction

    task automatic model_step(input logic i, p, pu, po, input logic [PW-1:0] j);
        logic [PW-1:0] nxt, flow;
        nxt  = m_pc + PW'(1);
        flow = i ? nxt : j;
        if (st) return;
        if (po) begin
            if (m_stk.size() > 0) begin
                logic [PW-1:0] top;
                top  = m_stk.pop_back();
                m_pc = p ? top : flow;
            end else begin
                m_unf = 1'b1;
                m_pc  = p ? nxt : flow;
            end
        end else begin
            if (pu) begin
                if (m_stk.size() < D) m_stk.push_back(nxt);
                else m_ovf = 1'b1;
            end
            m_pc = flow;
        end
    endtask

    task automatic step(input logic i, p, pu, po, input logic [PW-1:0] j);
        @(negedge clk);
        reset         = 1'b0;
        bus.s_inc     = i;
        bus.s_pila    = p;
        bus.push      = pu;
        bus.pop       = po;
        bus.jump_addr = j;
        model_step(i, p, pu, po, j);
        q.push_back(snapshot());
    endtask

    // Reset lands mid-cycle and is checked right away, not at an edge.
    task automatic do_reset();
        @(negedge clk);
        m_pc = '0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        q.push_back(snapshot());
        #2 reset = 1'b1;
        ->sample_ev;
    endtask

    always begin
        exp_t e;
        @(posedge clk or sample_ev);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            compared++;
            if (bus.pc !== e.pc || bus.sp !== e.sp || bus.stack_full !== e.full ||
                bus.stack_empty !== e.empty || bus.stack_overflow !== e.ovf ||
                bus.stack_underflow !== e.unf) begin
                mismatched++;
                $display("FAIL state t=%0t got pc=%h sp=%0d full=%b empty=%b ovf=%b unf=%b want pc=%h sp=%0d full=%b empty=%b ovf=%b unf=%b",
                         $time, bus.pc, bus.sp, bus.stack_full, bus.stack_empty,
                         bus.stack_overflow, bus.stack_underflow,
                         e.pc, e.sp, e.full, e.empty, e.ovf, e.unf);
            end
        end
    end

    initial begin
        bus.s_inc = 1'b1;
        bus.s_pila = 1'b0;
        bus.push = 1'b0;
        bus.pop = 1'b0;
        bus.jump_addr = '0;
        do_reset();
        repeat (5) step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        do_reset();
        repeat (3) step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 10'h120);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0);
        do_reset();
        repeat (9) step(1, 0, 1, 0, 0);
        repeat (8) step(1, 1, 0, 1, 0);
        do_reset();
        step(1, 1, 0, 1, 0);
        repeat (10) step(1, 0, 0, 0, 0);
        do_reset();
        step(0, 0, 0, 0, 10'h3FF);
        step(1, 0, 1, 0, 0);
        step(1, 1, 0, 1, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 1, 0);
        step(0, 0, 0, 1, 10'h0AB);
`ifdef PC_STACK_STALL_EN
        do_reset();
        step(1, 0, 0, 0, 0);
        st = 1'b1;
        repeat (3) step(0, 0, 1, 0, 10'h155);
        st = 1'b0;
        step(0, 0, 1, 0, 10'h155);
`endif
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
`ifdef PC_STACK_STALL_EN
                st = $urandom_range(0, 7) == 0;
`endif
                step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                     PW'($urandom));
            end
        end
        @(posedge clk);
        #3;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
